// File: rtl/pr_region_ctrl.sv
// Partial-reconfiguration controller: isolates one of NUM_RP partitions, streams a
// bitstream into an ICAP-style port, pulses the partition module reset, then releases it.
module pr_region_ctrl #(
  parameter int NUM_RP      = 4,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 20,
  parameter int DCPL_CYCLES = 4,
  parameter int RST_CYCLES  = 16,
  parameter int TIMEOUT     = 1023,
  parameter int BIT_SWAP    = 1,
  localparam int RP_W       = (NUM_RP > 1) ? $clog2(NUM_RP) : 1
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [RP_W-1:0]   req_rp,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] cfg_data,
  output logic              cfg_csib,
  output logic              cfg_rdwrb,
  input  logic              cfg_wait,
  output logic [NUM_RP-1:0] decouple,
  output logic [NUM_RP-1:0] rm_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_MAX = (DCPL_CYCLES > RST_CYCLES) ? DCPL_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DECOUPLE = 3'd1;
  localparam logic [2:0] ST_STREAM   = 3'd2;
  localparam logic [2:0] ST_RESET    = 3'd3;
  localparam logic [2:0] ST_RELEASE  = 3'd4;

  // Bit i of every byte moves to bit 7-i of the same byte; byte order is kept.
  function automatic logic [DATA_W-1:0] f_bit_swap(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    for (int b = 0; b < DATA_W / 8; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b + i] = d[8*b + 7 - i];
      end
    end
    return r;
  endfunction

  logic [2:0]        r_state;
  logic [RP_W-1:0]   r_rp;
  logic [LEN_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDLE_W-1:0] r_idle;
  logic [DATA_W-1:0] r_cfg_data;
  logic              r_csib;
  logic [NUM_RP-1:0] r_decouple;
  logic [NUM_RP-1:0] r_rm_rst_n;
  logic              r_started;
  logic              r_done;
  logic              r_err;

  logic              w_rp_ok;
  logic              w_beat;
  logic [NUM_RP-1:0] w_req_mask;
  logic [NUM_RP-1:0] w_sel;
  logic [DATA_W-1:0] w_word;

  assign w_rp_ok    = (32'(req_rp) < 32'(NUM_RP));
  assign w_req_mask = NUM_RP'(1) << req_rp;
  assign w_sel      = NUM_RP'(1) << r_rp;
  assign w_word     = (BIT_SWAP != 0) ? f_bit_swap(s_data) : s_data;

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign s_ready   = (r_state == ST_STREAM) & ~cfg_wait;
  assign w_beat    = s_valid & s_ready;

  assign cfg_data  = r_cfg_data;
  assign cfg_csib  = r_csib;
  assign cfg_rdwrb = 1'b0;
  assign decouple  = r_decouple;
  assign rm_rst_n  = r_rm_rst_n;
  assign done      = r_done;
  assign err       = r_err;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= ST_IDLE;
      r_rp       <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_idle     <= '0;
      r_cfg_data <= '0;
      r_csib     <= 1'b1;
      r_decouple <= '0;
      r_rm_rst_n <= '0;
      r_started  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_csib <= 1'b1;
      // Module resets come out of reset together on the first edge after RST_n rises.
      if (!r_started) begin
        r_started  <= 1'b1;
        r_rm_rst_n <= '1;
      end

      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            if (w_rp_ok) begin
              r_rp       <= req_rp;
              r_rem      <= req_len;
              r_cnt      <= '0;
              r_decouple <= r_decouple | w_req_mask;
              r_state    <= ST_DECOUPLE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        ST_DECOUPLE: begin
          if (r_cnt == CNT_W'(DCPL_CYCLES - 1)) begin
            r_cnt  <= '0;
            r_idle <= '0;
            if (r_rem == '0) begin
              r_rm_rst_n <= r_rm_rst_n & ~w_sel;
              r_state    <= ST_RESET;
            end else begin
              r_state <= ST_STREAM;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_STREAM: begin
          if (w_beat) begin
            r_cfg_data <= w_word;
            r_csib     <= 1'b0;
            r_idle     <= '0;
            r_rem      <= r_rem - 1'b1;
            if (r_rem == LEN_W'(1)) begin
              r_cnt      <= '0;
              r_rm_rst_n <= r_rm_rst_n & ~w_sel;
              r_state    <= ST_RESET;
            end
          end else if (r_idle == IDLE_W'(TIMEOUT - 1)) begin
            // Abort leaves the partition isolated and held in reset until reloaded.
            r_err      <= 1'b1;
            r_rm_rst_n <= r_rm_rst_n & ~w_sel;
            r_state    <= ST_IDLE;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end

        ST_RESET: begin
          if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
            r_rm_rst_n <= r_rm_rst_n | w_sel;
            r_decouple <= r_decouple & ~w_sel;
            r_done     <= 1'b1;
            r_state    <= ST_RELEASE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_RELEASE: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pr_region_ctrl.sv
// Self-checking bench for pr_region_ctrl: table-driven requests with a cfg_data
// scoreboard, plus hand sequences for reject, timeout/recovery and async reset.
module tb_pr_region_ctrl;

  localparam int DCPL = 4;
  localparam int RSTC = 16;
  localparam int TMO  = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_rp;
  logic [19:0] req_len;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] cfg_data;
  logic        cfg_csib;
  logic        cfg_rdwrb;
  logic        cfg_wait;
  logic [3:0]  decouple;
  logic [3:0]  rm_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  // A 4-partition build cannot encode index 5, so rejects use a 5-partition build.
  logic        r5_req_valid;
  logic        r5_req_ready;
  logic [2:0]  r5_req_rp;
  logic        r5_s_ready;
  logic [31:0] r5_cfg_data;
  logic        r5_cfg_csib;
  logic        r5_cfg_rdwrb;
  logic [4:0]  r5_decouple;
  logic [4:0]  r5_rm_rst_n;
  logic        r5_busy;
  logic        r5_done;
  logic        r5_err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  pr_region_ctrl #(
    .NUM_RP(4), .DATA_W(32), .LEN_W(20), .DCPL_CYCLES(DCPL),
    .RST_CYCLES(RSTC), .TIMEOUT(TMO), .BIT_SWAP(1)
  ) u_dut (
    .CLK(clk), .RST_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rp(req_rp), .req_len(req_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_data(cfg_data), .cfg_csib(cfg_csib), .cfg_rdwrb(cfg_rdwrb), .cfg_wait(cfg_wait),
    .decouple(decouple), .rm_rst_n(rm_rst_n),
    .busy(busy), .done(done), .err(err)
  );

  pr_region_ctrl #(
    .NUM_RP(5), .DATA_W(32), .LEN_W(20), .DCPL_CYCLES(DCPL),
    .RST_CYCLES(RSTC), .TIMEOUT(TMO), .BIT_SWAP(1)
  ) u_dut5 (
    .CLK(clk), .RST_n(rst_n),
    .req_valid(r5_req_valid), .req_ready(r5_req_ready), .req_rp(r5_req_rp), .req_len(20'd0),
    .s_data(32'd0), .s_valid(1'b0), .s_ready(r5_s_ready),
    .cfg_data(r5_cfg_data), .cfg_csib(r5_cfg_csib), .cfg_rdwrb(r5_cfg_rdwrb), .cfg_wait(1'b0),
    .decouple(r5_decouple), .rm_rst_n(r5_rm_rst_n),
    .busy(r5_busy), .done(r5_done), .err(r5_err)
  );

  typedef struct {
    int          rp;
    int          len;
    int          wmode;      // 0: cfg_wait low, 1: toggles each cycle, 2: random
    logic [31:0] base;
    logic [31:0] exp_dec;    // decouple while the request is in flight
    logic [31:0] exp_after;  // decouple once done has pulsed
    int          exp_low;    // rm_rst_n[rp] low samples leading up to done
    logic [31:0] exp_first;  // first cfg_data word, 0 = not checked
  } vec_t;

  vec_t tbl[5];

  function automatic logic [31:0] swap_model(input logic [31:0] w);
    logic [31:0] r;
    logic [7:0]  b;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      r[8*k +: 8] = {<<{b}};
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, resolve handshake at negedge, check registered write after the edge.
  task automatic tick(input logic sv, input logic [31:0] sd, input logic wt,
                      output logic hs, output logic rdy);
    logic [31:0] exp;
    s_valid  = sv;
    s_data   = sd;
    cfg_wait = wt;
    @(negedge clk);
    rdy = s_ready;
    hs  = sv && s_ready;
    if (hs) sb_q.push_back(swap_model(sd));
    @(posedge clk);
    #1;
    if (hs) begin
      exp = sb_q.pop_front();
      chk("cfg_data", cfg_data, exp);
      chk("cfg_csib_beat", 32'(cfg_csib), 0);
    end else begin
      chk("cfg_csib_idle", 32'(cfg_csib), 1);
    end
  endtask

  task automatic run_req(input vec_t v);
    logic        hs, rdy, wt;
    logic [31:0] w;
    int          sent, low_run, first_rdy;
    bit          done_seen;
    for (int i = 0; i < 10 && busy; i++) tick(1'b0, 32'd0, 1'b0, hs, rdy);
    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_rp    = v.rp[1:0];
    req_len   = v.len[19:0];
    tick(1'b0, 32'd0, 1'b0, hs, rdy);
    req_valid = 1'b0;
    sent = 0; low_run = 0; first_rdy = -1; done_seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (done) begin
        done_seen = 1;
        break;
      end
      chk("busy_active", 32'(busy), 1);
      chk("decouple_active", 32'(decouple), v.exp_dec);
      low_run = rm_rst_n[v.rp] ? 0 : low_run + 1;
      case (v.wmode)
        0:       wt = 1'b0;
        1:       wt = c[0];
        default: wt = 1'($urandom_range(0, 1));
      endcase
      w = v.base + 32'(sent) * 32'h0403_0201;
      tick(1'b1, w, wt, hs, rdy);
      if (rdy && first_rdy < 0) first_rdy = c;
      if (hs) begin
        sent++;
        if (sent == 1 && v.exp_first != 0) chk("first_word", cfg_data, v.exp_first);
      end
    end
    chk("done_seen", 32'(done_seen), 1);
    chk("decouple_after", 32'(decouple), v.exp_after);
    chk("rm_rst_release", 32'(rm_rst_n[v.rp]), 1);
    chk("rm_low_cycles", 32'(low_run), 32'(v.exp_low));
    chk("beats_accepted", 32'(sent), 32'(v.len));
    if (v.wmode == 0 && v.len > 0) chk("first_s_ready", 32'(first_rdy), DCPL);
    tick(1'b0, 32'd0, 1'b0, hs, rdy);
    chk("done_pulse_end", 32'(done), 0);
    chk("busy_end", 32'(busy), 0);
    chk("req_ready_end", 32'(req_ready), 1);
    chk("sb_empty", 32'(sb_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic hs, rdy;
    int   k;

    tbl[0] = '{rp:2, len:3, wmode:0, base:32'h0102_0380, exp_dec:32'h4, exp_after:32'h0, exp_low:RSTC, exp_first:32'h8040_C001};
    tbl[1] = '{rp:2, len:3, wmode:1, base:32'h0102_0380, exp_dec:32'h4, exp_after:32'h0, exp_low:RSTC, exp_first:32'h8040_C001};
    tbl[2] = '{rp:0, len:0, wmode:0, base:32'h0,         exp_dec:32'h1, exp_after:32'h0, exp_low:RSTC, exp_first:32'h0};
    tbl[3] = '{rp:3, len:5, wmode:2, base:32'hA5C3_1E77, exp_dec:32'h8, exp_after:32'h0, exp_low:RSTC, exp_first:32'h0};
    tbl[4] = '{rp:1, len:1, wmode:1, base:32'hF00F_1234, exp_dec:32'h2, exp_after:32'h0, exp_low:RSTC, exp_first:32'h0};

    rst_n = 1'b0; req_valid = 1'b0; req_rp = '0; req_len = '0;
    s_data = '0; s_valid = 1'b0; cfg_wait = 1'b0;
    r5_req_valid = 1'b0; r5_req_rp = '0;
    #23;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_cfg_data", cfg_data, 0);
    chk("rst_cfg_csib", 32'(cfg_csib), 1);
    chk("rst_cfg_rdwrb", 32'(cfg_rdwrb), 0);
    chk("rst_decouple", 32'(decouple), 0);
    chk("rst_rm_rst_n", 32'(rm_rst_n), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rm_rst_n_first_edge", 32'(rm_rst_n), 32'hF);
    chk("r5_rm_rst_n_first_edge", 32'(r5_rm_rst_n), 32'h1F);

    for (int i = 0; i < 5; i++) run_req(tbl[i]);

    // Out-of-range partition index is rejected with a lone err pulse.
    for (int j = 5; j < 7; j++) begin
      r5_req_valid = 1'b1;
      r5_req_rp    = 3'(j);
      @(posedge clk);
      #1;
      r5_req_valid = 1'b0;
      chk("reject_err", 32'(r5_err), 1);
      chk("reject_busy", 32'(r5_busy), 0);
      chk("reject_decouple", 32'(r5_decouple), 0);
      chk("reject_req_ready", 32'(r5_req_ready), 1);
      chk("reject_rm_rst_n", 32'(r5_rm_rst_n), 32'h1F);
      @(posedge clk);
      #1;
      chk("reject_err_pulse", 32'(r5_err), 0);
    end

    // Stream stalls after two of four words: abort after TMO idle cycles.
    req_valid = 1'b1; req_rp = 2'd1; req_len = 20'd4;
    tick(1'b0, 32'd0, 1'b0, hs, rdy);
    req_valid = 1'b0;
    for (int i = 0; i < DCPL; i++) tick(1'b0, 32'd0, 1'b0, hs, rdy);
    tick(1'b1, 32'h1111_2222, 1'b0, hs, rdy);
    chk("to_beat0", 32'(hs), 1);
    tick(1'b1, 32'h3333_4444, 1'b0, hs, rdy);
    chk("to_beat1", 32'(hs), 1);
    k = 0;
    for (int n = 1; n <= TMO + 80; n++) begin
      tick(1'b0, 32'd0, 1'b0, hs, rdy);
      if (err) begin
        k = n;
        break;
      end
    end
    chk("timeout_cycles", 32'(k), TMO);
    chk("timeout_busy", 32'(busy), 0);
    chk("timeout_req_ready", 32'(req_ready), 1);
    chk("timeout_decouple", 32'(decouple), 32'h2);
    chk("timeout_rm_rst_n", 32'(rm_rst_n), 32'hD);
    tick(1'b0, 32'd0, 1'b0, hs, rdy);
    chk("timeout_err_pulse", 32'(err), 0);
    chk("timeout_decouple_hold", 32'(decouple), 32'h2);
    chk("timeout_rm_hold", 32'(rm_rst_n), 32'hD);

    // Reload of the aborted partition: it was already in reset before the accept.
    run_req('{rp:1, len:2, wmode:0, base:32'h0BAD_F00D, exp_dec:32'h2, exp_after:32'h0,
              exp_low:DCPL + 2 + RSTC, exp_first:32'h0});
    chk("recover_rm_rst_n", 32'(rm_rst_n), 32'hF);

    // Asynchronous reset in the middle of a stream.
    req_valid = 1'b1; req_rp = 2'd3; req_len = 20'd4;
    tick(1'b0, 32'd0, 1'b0, hs, rdy);
    req_valid = 1'b0;
    for (int i = 0; i < DCPL; i++) tick(1'b1, 32'h5A5A_0F0F, 1'b0, hs, rdy);
    tick(1'b1, 32'h5A5A_0F0F, 1'b0, hs, rdy);
    chk("ar_beat", 32'(hs), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_cfg_data", cfg_data, 0);
    chk("ar_cfg_csib", 32'(cfg_csib), 1);
    chk("ar_decouple", 32'(decouple), 0);
    chk("ar_rm_rst_n", 32'(rm_rst_n), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_s_ready", 32'(s_ready), 0);
    chk("ar_req_ready", 32'(req_ready), 1);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ar_rm_before_edge", 32'(rm_rst_n), 0);
    tick(1'b0, 32'd0, 1'b0, hs, rdy);
    chk("ar_rm_after_edge", 32'(rm_rst_n), 32'hF);
    chk("ar_req_ready_after", 32'(req_ready), 1);
    chk("ar_busy_after", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
